// File: rtl/send_buffer_arb.sv
// Multi-channel send buffer: Avalon-MM writes fill per-channel FIFOs, and the consumer pops a show-ahead word from the arbitrated channel.
// Push-to-visible latency is 1 cycle. Writes to a full channel are dropped and flagged, and pops while nothing is ready are ignored and flagged.
module send_buffer_arb #(
    parameter int DATA_W   = 256,
    parameter int NUM_CH   = 4,
    parameter int DEPTH    = 8,
    parameter int ADDR_W   = 10,
    parameter int CH_LSB   = 3,
    parameter int ARB_MODE = 0,
    localparam int CH_W    = $clog2(NUM_CH),
    localparam int CNT_W   = $clog2(DEPTH + 1)
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [ADDR_W-1:0]   address,
    input  logic                chipselect,
    input  logic                write,
    input  logic                read,
    input  logic [DATA_W-1:0]   writedata,
    input  logic [DATA_W/8-1:0] byteenable,
    output logic [DATA_W-1:0]   readdata,
    output logic [DATA_W-1:0]   dataOut,
    output logic [CH_W-1:0]     dataChannel,
    output logic                ready,
    input  logic                dataPop,
    output logic [NUM_CH-1:0]   emptyArray,
    output logic [NUM_CH-1:0]   fullArray
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [DATA_W-1:0] mem    [NUM_CH][DEPTH];
    logic [PTR_W-1:0]  rd_ptr [NUM_CH];
    logic [PTR_W-1:0]  wr_ptr [NUM_CH];
    logic [CNT_W-1:0]  count  [NUM_CH];
    logic [NUM_CH-1:0] overflow;
    logic              underrun;
    logic [CH_W-1:0]   rr_ptr;

    logic [NUM_CH-1:0] empty_v, full_v, push_hit, pop_hit, ovf_evt;
    logic [CH_W-1:0]   grant, cand, push_ch;
    logic              found, push, pop, und_evt, status_rd;
    logic [DATA_W-1:0] wdata_m, status_word;
    logic [7:0]        cnt8;

    assign push      = chipselect & write;
    assign status_rd = chipselect & read;
    assign push_ch   = address[CH_LSB +: CH_W];
    assign pop       = dataPop & ready;
    assign und_evt   = dataPop & ~ready;

    always_comb begin
        empty_v = '0;
        full_v  = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            empty_v[c] = (count[c] == '0);
            full_v[c]  = (count[c] == CNT_W'(DEPTH));
        end
    end

    // Search order starts at rr_ptr in round-robin mode, at ch0 otherwise.
    always_comb begin
        grant = '0;
        found = 1'b0;
        cand  = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            cand = (ARB_MODE == 1) ? rr_ptr + CH_W'(i) : CH_W'(i);
            if (!found && !empty_v[cand]) begin
                grant = cand;
                found = 1'b1;
            end
        end
    end

    assign ready       = ~&empty_v;
    assign dataOut     = mem[grant][rd_ptr[grant]];
    assign dataChannel = grant;
    assign emptyArray  = empty_v;
    assign fullArray   = full_v;

    always_comb begin
        wdata_m = '0;
        for (int b = 0; b < DATA_W / 8; b++)
            wdata_m[8*b +: 8] = byteenable[b] ? writedata[8*b +: 8] : 8'h00;
    end

    // Fullness is judged on the pre-cycle count, so a same-cycle pop never makes room.
    always_comb begin
        push_hit = '0;
        pop_hit  = '0;
        ovf_evt  = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            push_hit[c] = push && (push_ch == CH_W'(c)) && !full_v[c];
            ovf_evt[c]  = push && (push_ch == CH_W'(c)) && full_v[c];
            pop_hit[c]  = pop && (grant == CH_W'(c));
        end
    end

    always_comb begin
        status_word = '0;
        cnt8        = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            cnt8 = 8'(count[c]);
            status_word[16*c +: 16] = {overflow[c], full_v[c], empty_v[c], 5'b0, cnt8};
        end
        status_word[DATA_W-1] = underrun;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int c = 0; c < NUM_CH; c++) begin
                for (int d = 0; d < DEPTH; d++)
                    mem[c][d] <= '0;
                rd_ptr[c] <= '0;
                wr_ptr[c] <= '0;
                count[c]  <= '0;
            end
            overflow <= '0;
            underrun <= 1'b0;
            rr_ptr   <= '0;
            readdata <= '0;
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (push_hit[c]) begin
                    mem[c][wr_ptr[c]] <= wdata_m;
                    wr_ptr[c]         <= wr_ptr[c] + 1'b1;
                end
                if (pop_hit[c])
                    rd_ptr[c] <= rd_ptr[c] + 1'b1;
                case ({push_hit[c], pop_hit[c]})
                    2'b10:   count[c] <= count[c] + 1'b1;
                    2'b01:   count[c] <= count[c] - 1'b1;
                    default: count[c] <= count[c];
                endcase
            end
            // Clear-on-read keeps any event that lands in the read cycle itself.
            if (status_rd) begin
                readdata <= status_word;
                overflow <= ovf_evt;
                underrun <= und_evt;
            end else begin
                overflow <= overflow | ovf_evt;
                underrun <= underrun | und_evt;
            end
            if (pop)
                rr_ptr <= grant + 1'b1;
        end
    end
endmodule

// File: tb/tb_send_buffer_arb.sv
// Bench: fixed-priority and round-robin instances share stimulus; a queue-based reference model feeds a scoreboard.
module tb_send_buffer_arb;
    localparam int DW    = 256;
    localparam int NCH   = 4;
    localparam int DEPTH = 8;

    typedef logic [DW+1:0] pop_t;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic [9:0]      address = '0;
    logic            chipselect = 1'b0, write = 1'b0, read = 1'b0, dataPop = 1'b0;
    logic [DW-1:0]   writedata = '0;
    logic [DW/8-1:0] byteenable = '0;

    logic [DW-1:0]   readdata_o [2];
    logic [DW-1:0]   dout       [2];
    logic [1:0]      dch        [2];
    logic            rdy        [2];
    logic [NCH-1:0]  ea         [2];
    logic [NCH-1:0]  fa         [2];

    always #5 clk = ~clk;

    send_buffer_arb #(.ARB_MODE(0)) u_fp (
        .clock(clk), .reset(reset), .address(address), .chipselect(chipselect),
        .write(write), .read(read), .writedata(writedata), .byteenable(byteenable),
        .readdata(readdata_o[0]), .dataOut(dout[0]), .dataChannel(dch[0]), .ready(rdy[0]),
        .dataPop(dataPop), .emptyArray(ea[0]), .fullArray(fa[0]));

    send_buffer_arb #(.ARB_MODE(1)) u_rr (
        .clock(clk), .reset(reset), .address(address), .chipselect(chipselect),
        .write(write), .read(read), .writedata(writedata), .byteenable(byteenable),
        .readdata(readdata_o[1]), .dataOut(dout[1]), .dataChannel(dch[1]), .ready(rdy[1]),
        .dataPop(dataPop), .emptyArray(ea[1]), .fullArray(fa[1]));

    // Reference model state: index 0 = fixed priority, 1 = round robin
    logic [DW-1:0]  mq [2*NCH][$];
    logic [NCH-1:0] m_ovf [2];
    logic           m_und [2];
    int             m_rr  [2];

    logic [2*NCH:0] exp_flags [2][$];
    pop_t           exp_pop   [2][$];
    logic [DW-1:0]  exp_rd    [2][$];
    logic           rd_pend   [2];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input int m, input pop_t act, input pop_t exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s inst%0d: got %h required %h", nm, m, act, exp_v);
        end
    endtask

    task automatic model_clear();
        for (int m = 0; m < 2; m++) begin
            for (int c = 0; c < NCH; c++) mq[m*NCH+c].delete();
            m_ovf[m] = '0;
            m_und[m] = 1'b0;
            m_rr[m]  = 0;
        end
    endtask

    task automatic model_step(input int m);
        int g, ch, pc;
        bit any, do_push;
        logic [NCH-1:0] emp, ful, new_ovf;
        logic new_und;
        logic [DW-1:0] sw, wm;
        any = 0; g = 0;
        for (int k = 0; k < NCH; k++) begin
            ch = (m == 1) ? (m_rr[m] + k) % NCH : k;
            if (!any && mq[m*NCH+ch].size() > 0) begin g = ch; any = 1; end
        end
        for (int k = 0; k < NCH; k++) begin
            emp[k] = (mq[m*NCH+k].size() == 0);
            ful[k] = (mq[m*NCH+k].size() == DEPTH);
        end
        exp_flags[m].push_back({any, emp, ful});
        if (chipselect && read) begin
            sw = '0;
            for (int k = 0; k < NCH; k++)
                sw[16*k +: 16] = {m_ovf[m][k], ful[k], emp[k], 5'b0, 8'(mq[m*NCH+k].size())};
            sw[DW-1] = m_und[m];
            exp_rd[m].push_back(sw);
        end
        new_ovf = '0; new_und = 1'b0; do_push = 0;
        pc = int'(address[4:3]);
        wm = '0;
        for (int b = 0; b < DW/8; b++) if (byteenable[b]) wm[8*b +: 8] = writedata[8*b +: 8];
        if (chipselect && write) begin
            if (ful[pc]) new_ovf[pc] = 1'b1;
            else do_push = 1;
        end
        if (dataPop) begin
            if (any) begin
                exp_pop[m].push_back({mq[m*NCH+g][0], 2'(g)});
                void'(mq[m*NCH+g].pop_front());
                m_rr[m] = (g + 1) % NCH;
            end else new_und = 1'b1;
        end
        if (do_push) mq[m*NCH+pc].push_back(wm);
        if (chipselect && read) begin
            m_ovf[m] = new_ovf; m_und[m] = new_und;
        end else begin
            m_ovf[m] = m_ovf[m] | new_ovf; m_und[m] = m_und[m] | new_und;
        end
    endtask

    task automatic drive(input logic cs, input logic w, input logic r, input logic [9:0] a,
                         input logic [DW-1:0] d, input logic [DW/8-1:0] be, input logic p);
        @(posedge clk); #1;
        reset = 1'b0;
        chipselect = cs; write = w; read = r; address = a;
        writedata = d; byteenable = be; dataPop = p;
        for (int m = 0; m < 2; m++) model_step(m);
    endtask

    task automatic idle();
        drive(0, 0, 0, '0, '0, '0, 0);
    endtask
    task automatic wr(input int c, input logic [DW-1:0] d);
        drive(1, 1, 0, 10'(c * 8), d, '1, 0);
    endtask
    task automatic rd_status();
        drive(1, 0, 1, '0, '0, '0, 0);
    endtask
    task automatic pop1();
        drive(0, 0, 0, '0, '0, '0, 1);
    endtask

    task automatic do_reset();
        idle();
        @(posedge clk); #1;
        reset = 1'b1;
        chipselect = 0; write = 0; read = 0; dataPop = 0;
        model_clear();
        for (int m = 0; m < 2; m++) model_step(m);
    endtask

    function automatic logic [DW-1:0] rnd256();
        logic [DW-1:0] v;
        for (int i = 0; i < DW/32; i++) v[32*i +: 32] = $urandom;
        return v;
    endfunction

    // Monitor: pops scoreboard entries whenever the DUT presents a response
    always @(negedge clk) begin
        logic [2*NCH:0] f;
        pop_t pe;
        logic [DW-1:0] re;
        for (int m = 0; m < 2; m++) begin
            if (exp_flags[m].size() > 0) begin
                f = exp_flags[m].pop_front();
                chk("ready_empty_full", m, pop_t'({rdy[m], ea[m], fa[m]}), pop_t'(f));
            end
            if (rd_pend[m]) begin
                if (exp_rd[m].size() == 0) begin
                    checks++; errors++;
                    $display("FAIL readdata inst%0d: got %h required none", m, readdata_o[m]);
                end else begin
                    re = exp_rd[m].pop_front();
                    chk("readdata", m, pop_t'(readdata_o[m]), pop_t'(re));
                end
            end
            rd_pend[m] = chipselect && read && !reset;
            if (dataPop && rdy[m] && !reset) begin
                if (exp_pop[m].size() == 0) begin
                    checks++; errors++;
                    $display("FAIL pop inst%0d: got ch%0d required no pop", m, dch[m]);
                end else begin
                    pe = exp_pop[m].pop_front();
                    chk("pop_data_channel", m, {dout[m], dch[m]}, pe);
                end
            end
            if (reset) chk("reset_readdata", m, pop_t'(readdata_o[m]), '0);
        end
    end

    initial begin
        logic [DW-1:0] ones;
        rd_pend[0] = 1'b0; rd_pend[1] = 1'b0;
        model_clear();
        do_reset();

        // Reset mid-operation
        for (int i = 0; i < 3; i++) wr(1, rnd256());
        rd_status();
        do_reset();
        idle();

        // Fill and overflow ch2, then clear-on-read
        for (int i = 0; i < 9; i++) wr(2, rnd256());
        rd_status();
        rd_status();
        idle();
        for (int i = 0; i < 8; i++) pop1();

        // Fixed priority ordering
        do_reset();
        wr(3, {8{32'hAAAA_AAAA}});
        wr(1, {8{32'hBBBB_BBBB}});
        wr(0, {8{32'hCCCC_CCCC}});
        for (int i = 0; i < 3; i++) pop1();

        // Round-robin: two words per channel, back-to-back pops
        do_reset();
        for (int c = 0; c < NCH; c++) begin
            wr(c, rnd256());
            wr(c, rnd256());
        end
        for (int i = 0; i < 8; i++) pop1();
        idle();

        // Concurrent push and pop on ch0 at count 4
        do_reset();
        for (int i = 0; i < 4; i++) wr(0, rnd256());
        drive(1, 1, 0, 10'd0, rnd256(), '1, 1);
        rd_status();
        for (int i = 0; i < 4; i++) pop1();

        // Underrun and byteenable masking
        do_reset();
        pop1();
        rd_status();
        ones = '1;
        drive(1, 1, 0, 10'd0, ones, 32'h0000_000F, 0);
        pop1();
        rd_status();
        idle();

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            drive(($urandom_range(0, 9) < 8), ($urandom_range(0, 1) == 1),
                  ($urandom_range(0, 4) == 0), 10'($urandom), rnd256(),
                  ($urandom_range(0, 1) == 1) ? '1 : DW'(0) | 32'($urandom),
                  ($urandom_range(0, 9) < 4));
        end
        idle();
        idle();
        @(posedge clk); #1;

        for (int m = 0; m < 2; m++) begin
            chk("leftover_pops", m, pop_t'(exp_pop[m].size()), '0);
            chk("leftover_reads", m, pop_t'(exp_rd[m].size()), '0);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
